taco_order_uart_tx: RTL and testbench



---
 rtl/taco_order_uart_tx_if.sv | 25 ++
 rtl/taco_order_uart_tx.sv | 137 +++++++++++++
 tb/tb_taco_order_uart_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/taco_order_uart_tx_if.sv
// +--------------------------------------------------------------------------+
// | taco_order_uart_tx_if : order handshake between flavour decoder and TX   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface taco_order_uart_tx_if;
  logic [7:0] char_in;
  logic       order_valid;
  logic       order_ready;

  modport master (
    output char_in,
    output order_valid,
    input  order_ready
  );

  modport slave (
    input  char_in,
    input  order_valid,
    output order_ready
  );
endinterface

`default_nettype wire

// File: rtl/taco_order_uart_tx.sv
// +--------------------------------------------------------------------------+
// | taco_order_uart_tx : 8N1 serialiser for flavour codes, optional LF tail  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module taco_order_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit APPEND_LF    = 1'b1
) (
  input  wire                       clk,
  input  wire                       rst_n,
  taco_order_uart_tx_if.slave       ord,
  output logic                      tx,
  output logic                      busy,
  output logic                      err,
  output logic [7:0]                sent_count
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  LF_CHAR  = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  idx, idx_d;
  logic [7:0]  data, data_d;
  logic [7:0]  sent_count_d;
  logic        err_d;
  logic        tx_d;
  logic        code_ok;
  logic        bit_done;

  // X/Z bits make the compare unknown, which falls through to the drop path
  assign code_ok  = (ord.char_in == 8'h43) || (ord.char_in == 8'h44) ||
                    (ord.char_in == 8'h46) || (ord.char_in == 8'h50);
  assign bit_done = (cnt == LAST_CNT);

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    idx_d        = idx;
    data_d       = data;
    sent_count_d = sent_count;
    err_d        = 1'b0;

    case (state)
      IDLE: begin
        if (ord.order_valid && ord.order_ready) begin
          if (code_ok) begin
            state_d = START;
            data_d  = ord.char_in;
            cnt_d   = 16'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = 16'd0;
          if (idx == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d = 16'd0;
          // Flavour codes never equal LF, so the held byte tells which frame ended
          if (APPEND_LF && (data != LF_CHAR)) begin
            data_d  = LF_CHAR;
            state_d = START;
          end else begin
            state_d      = IDLE;
            sent_count_d = sent_count + 8'd1;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 16'd0;
      idx             <= 3'd0;
      data            <= 8'd0;
      sent_count      <= 8'd0;
      err             <= 1'b0;
      tx              <= 1'b1;
      busy            <= 1'b0;
      ord.order_ready <= 1'b1;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      idx             <= idx_d;
      data            <= data_d;
      sent_count      <= sent_count_d;
      err             <= err_d;
      tx              <= tx_d;
      busy            <= (state_d != IDLE);
      ord.order_ready <= (state_d == IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_taco_order_uart_tx.sv
// +--------------------------------------------------------------------------+
// | tb_taco_order_uart_tx : directed bench for taco_order_uart_tx            |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_taco_order_uart_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  taco_order_uart_tx_if if_a ();
  taco_order_uart_tx_if if_b ();
  taco_order_uart_tx_if if_c ();

  logic       tx_a, busy_a, err_a;
  logic       tx_b, busy_b, err_b;
  logic       tx_c, busy_c, err_c;
  logic [7:0] cnt_a, cnt_b, cnt_c;

  taco_order_uart_tx #(.CLKS_PER_BIT(4), .APPEND_LF(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ord(if_a),
    .tx(tx_a), .busy(busy_a), .err(err_a), .sent_count(cnt_a)
  );

  taco_order_uart_tx #(.CLKS_PER_BIT(4), .APPEND_LF(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ord(if_b),
    .tx(tx_b), .busy(busy_b), .err(err_b), .sent_count(cnt_b)
  );

  taco_order_uart_tx #(.CLKS_PER_BIT(1), .APPEND_LF(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .ord(if_c),
    .tx(tx_c), .busy(busy_c), .err(err_c), .sent_count(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line levels per bit period, index 0 = start bit (0x43 then LF; 0x50 alone)
  logic [19:0] exp_frame_43lf = 20'b1000_0101_0010_1000_0110;
  logic [9:0]  exp_frame_50   = 10'b10_1010_0000;
  int          cyc;

  initial begin
    if_a.char_in = 8'h00; if_a.order_valid = 1'b0;
    if_b.char_in = 8'h00; if_b.order_valid = 1'b0;
    if_c.char_in = 8'h00; if_c.order_valid = 1'b0;

    // 1: reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx",    tx_a, 1'b1);
    check("rst_ready", if_a.order_ready, 1'b1);
    check("rst_busy",  busy_a, 1'b0);
    check("rst_err",   err_a, 1'b0);
    check("rst_count", cnt_a, 8'd0);
    rst_n = 1'b1;
    tick();

    // 2: 0x43 with LF tail on dut_a
    if_a.char_in = 8'h43; if_a.order_valid = 1'b1;
    tick();
    if_a.order_valid = 1'b0;
    check("c_busy", busy_a, 1'b1);
    for (int k = 0; k < 80; k++) begin
      check("c_tx",    tx_a, exp_frame_43lf[k/4]);
      check("c_ready", if_a.order_ready, 1'b0);
      tick();
    end
    check("c_ready_back", if_a.order_ready, 1'b1);
    check("c_busy_end",   busy_a, 1'b0);
    check("c_tx_idle",    tx_a, 1'b1);
    check("c_count",      cnt_a, 8'd1);

    // 3: invalid codes dropped with one-cycle err
    if_a.char_in = 8'hFF; if_a.order_valid = 1'b1;
    tick();
    if_a.order_valid = 1'b0;
    check("ff_err",   err_a, 1'b1);
    check("ff_tx",    tx_a, 1'b1);
    check("ff_ready", if_a.order_ready, 1'b1);
    tick();
    check("ff_err_clr", err_a, 1'b0);
    if_a.char_in = 8'hxx; if_a.order_valid = 1'b1;
    tick();
    if_a.order_valid = 1'b0;
    check("xx_err",  err_a, 1'b1);
    check("xx_busy", busy_a, 1'b0);
    tick();
    check("xx_err_clr", err_a, 1'b0);
    check("xx_tx",      tx_a, 1'b1);
    check("xx_count",   cnt_a, 8'd1);

    // 4: held valid on dut_b, no LF; next order taken on first ready cycle
    if_b.char_in = 8'h50; if_b.order_valid = 1'b1;
    tick();
    if_b.char_in = 8'h44;
    check("p_busy", busy_b, 1'b1);
    for (int k = 0; k < 40; k++) begin
      check("p_tx",    tx_b, exp_frame_50[k/4]);
      check("p_ready", if_b.order_ready, 1'b0);
      tick();
    end
    check("p_ready_back", if_b.order_ready, 1'b1);
    check("p_tx_no_lf",   tx_b, 1'b1);
    check("p_count",      cnt_b, 8'd1);
    tick();
    check("d_accept_busy",  busy_b, 1'b1);
    check("d_accept_ready", if_b.order_ready, 1'b0);
    check("d_start_tx",     tx_b, 1'b0);
    repeat (18) tick();
    if_b.order_valid = 1'b0;
    repeat (22) tick();
    check("d_ready_back", if_b.order_ready, 1'b1);
    check("d_count",      cnt_b, 8'd2);

    // 5: async reset in DATA bit 3 of 0x44 on dut_a
    if_a.char_in = 8'h44; if_a.order_valid = 1'b1;
    tick();
    if_a.order_valid = 1'b0;
    repeat (17) tick();
    check("r_pre_tx",   tx_a, 1'b0);
    check("r_pre_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("r_tx",    tx_a, 1'b1);
    check("r_busy",  busy_a, 1'b0);
    check("r_ready", if_a.order_ready, 1'b1);
    check("r_count", cnt_a, 8'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("r_idle_tx",    tx_a, 1'b1);
    check("r_idle_busy",  busy_a, 1'b0);
    check("r_idle_count", cnt_a, 8'd0);

    // 6: 256 back-to-back 0x46 at one clock per bit
    if_c.char_in = 8'h46; if_c.order_valid = 1'b1;
    cyc = 0;
    while ((cnt_c !== 8'd255) && (cyc < 4000)) begin
      tick();
      cyc++;
    end
    check("w_count255",  cnt_c, 8'd255);
    check("w_cycles",    cyc, 32'd2805);
    check("w_ready255",  if_c.order_ready, 1'b1);
    tick();
    if_c.order_valid = 1'b0;
    check("w_busy256", busy_c, 1'b1);
    repeat (10) tick();
    check("w_wrap",       cnt_c, 8'd0);
    check("w_ready_end",  if_c.order_ready, 1'b1);
    check("w_busy_end",   busy_c, 1'b0);
    check("w_tx_end",     tx_c, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
